fifo_gray_reader: RTL and testbench

Read-side consumer for the grayscale datapath byte FIFO. It pops interleaved R, G, B bytes from the FIFO read port, which has one-cycle registered read data. It converts each triple to an 8-bit luma value, gray = (77·R + 150·G + 29·B) >> 8, and presents the result on a valid/ready output stream. It sits directly downstream of the pixel FIFO and upstream of the grayscale frame writer.

---
 rtl/fifo_gray_reader.sv | 123 ++++++++++++
 tb/tb_fifo_gray_reader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_gray_reader.sv
// fifo_gray_reader
//   Read-side consumer of the pixel byte FIFO. Pops interleaved R, G, B
//   bytes (the FIFO has one-cycle registered read data). It turns each
//   triple into an 8-bit luma value, (77*R + 150*G + 29*B) >> 8, and
//   presents that value on a valid/ready stream.
//
//   Byte index state (idx):
//     state  | meaning
//     IDX_R  | next read fetches the R byte of a pixel
//     IDX_G  | next read fetches the G byte
//     IDX_B  | next read fetches the B byte; gated by output back-pressure
//
// Ports
//   clk          system clock, rising edge
//   rstn         asynchronous active-low reset
//   en           run enable; low stops new reads, in-flight work completes
//   fifo_empty   FIFO empty flag
//   fifo_rd      FIFO read strobe (never high while fifo_empty)
//   fifo_data    FIFO read data, valid the cycle after an accepted read
//   gray_out     luma result
//   gray_valid   gray_out holds an unconsumed pixel
//   gray_ready   downstream accepts gray_out
//   pixel_count  number of pixels handed downstream (wraps)

module fifo_gray_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  fifo_empty,
    output logic                  fifo_rd,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic [DATA_WIDTH-1:0] gray_out,
    output logic                  gray_valid,
    input  logic                  gray_ready,
    output logic [CNT_WIDTH-1:0]  pixel_count
);

    localparam int SUM_WIDTH = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDX_R = 2'd0,
        IDX_G = 2'd1,
        IDX_B = 2'd2
    } idx_t;

    idx_t                  idx;
    idx_t                  idx_next;
    idx_t                  idx_d;
    logic                  rd_d;
    logic [DATA_WIDTH-1:0] r_reg;
    logic [DATA_WIDTH-1:0] g_reg;
    logic [SUM_WIDTH-1:0]  sum;
    logic [DATA_WIDTH-1:0] luma;
    logic                  b_load;
    logic                  xfer;

    // The B read waits while an output is pending and not draining this
    // cycle, so a B capture can never land on top of an unconsumed pixel.
    always_comb begin
        fifo_rd  = rstn & en & ~fifo_empty &
                   ((idx != IDX_B) | ~gray_valid | gray_ready);
        idx_next = idx;
        if (fifo_rd) begin
            case (idx)
                IDX_R:   idx_next = IDX_G;
                IDX_G:   idx_next = IDX_B;
                default: idx_next = IDX_R;
            endcase
        end
    end

    // B is taken straight from the FIFO output on its capture cycle.
    // Max sum is 255*256 = 65280, so 16 bits never overflow.
    assign sum    = SUM_WIDTH'(77)  * SUM_WIDTH'(r_reg) +
                    SUM_WIDTH'(150) * SUM_WIDTH'(g_reg) +
                    SUM_WIDTH'(29)  * SUM_WIDTH'(fifo_data);
    assign luma   = DATA_WIDTH'(sum >> DATA_WIDTH);
    assign b_load = rd_d & (idx_d == IDX_B);
    assign xfer   = gray_valid & gray_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx   <= IDX_R;
            idx_d <= IDX_R;
            rd_d  <= 1'b0;
        end else begin
            idx   <= idx_next;
            idx_d <= idx;
            rd_d  <= fifo_rd;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_reg <= '0;
            g_reg <= '0;
        end else if (rd_d) begin
            if (idx_d == IDX_R) r_reg <= fifo_data;
            if (idx_d == IDX_G) g_reg <= fifo_data;
        end
    end

    // A new pixel load wins over a simultaneous hand-off clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gray_out    <= '0;
            gray_valid  <= 1'b0;
            pixel_count <= '0;
        end else begin
            if (b_load) begin
                gray_out   <= luma;
                gray_valid <= 1'b1;
            end else if (xfer) begin
                gray_valid <= 1'b0;
            end
            if (xfer) pixel_count <= pixel_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_fifo_gray_reader.sv
// Bench for fifo_gray_reader: a queue-based FIFO feeds the DUT, and the
// expected luma stream is computed from the pushed bytes in whole pixels.

module tb_fifo_gray_reader;

    logic        clk;
    logic        rstn;
    logic        en;
    logic        fifo_empty;
    logic        fifo_rd;
    logic [7:0]  fifo_data;
    logic [7:0]  gray_out;
    logic        gray_valid;
    logic        gray_ready;
    logic [15:0] pixel_count;

    fifo_gray_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .fifo_data  (fifo_data),
        .gray_out   (gray_out),
        .gray_valid (gray_valid),
        .gray_ready (gray_ready),
        .pixel_count(pixel_count)
    );

    always #5 clk = ~clk;

    logic [7:0] fq[$];
    logic [7:0] part[$];
    logic [7:0] exp_q[$];

    int   tests = 0;
    int   fails = 0;
    int   cyc_no = 0;
    int   rd_total = 0;
    int   win_rd = 0;
    int   last_b = -100;
    int   model_cnt = 0;
    bit   prev_hold = 0;
    bit   prev_valid = 0;
    logic [7:0] prev_out = '0;

    // FIFO with one-cycle registered read data
    always @(posedge clk) begin
        if (fifo_rd && fq.size() > 0) fifo_data <= fq.pop_front();
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        int s;
        fq.push_back(b);
        part.push_back(b);
        if (part.size() == 3) begin
            s = 77 * int'(part[0]) + 150 * int'(part[1]) + 29 * int'(part[2]);
            exp_q.push_back(8'(s >> 8));
            part.delete();
        end
    endtask

    // One clock cycle: drive inputs, check, then advance past the edge.
    task automatic cycle(input bit rdy, input bit env, input bit starve);
        gray_ready = rdy;
        en         = env;
        fifo_empty = starve || (fq.size() == 0);
        #1;
        check("rd_while_empty", {31'd0, fifo_rd && fifo_empty}, 0);
        check("pixel_count", {16'd0, pixel_count}, model_cnt);
        if (prev_hold) begin
            check("hold_valid", {31'd0, gray_valid}, 1);
            check("hold_data", {24'd0, gray_out}, {24'd0, prev_out});
        end
        if (gray_valid && !prev_valid) check("latency", cyc_no, last_b + 2);
        if (fifo_rd) begin
            rd_total++;
            win_rd++;
            if (rd_total % 3 == 0) last_b = cyc_no;
        end
        if (gray_valid && gray_ready) begin
            if (exp_q.size() == 0) check("spurious_out", 1, 0);
            else check("gray_out", {24'd0, gray_out}, {24'd0, exp_q.pop_front()});
            model_cnt = (model_cnt + 1) % 65536;
        end
        prev_hold  = gray_valid && !gray_ready;
        prev_out   = gray_out;
        prev_valid = gray_valid;
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    initial begin
        clk        = 0;
        rstn       = 0;
        en         = 1;
        fifo_empty = 0;
        gray_ready = 1;
        fifo_data  = '0;
        #1;
        check("rst_rd", {31'd0, fifo_rd}, 0);
        check("rst_valid", {31'd0, gray_valid}, 0);
        check("rst_out", {24'd0, gray_out}, 0);
        check("rst_count", {16'd0, pixel_count}, 0);
        #20;
        @(posedge clk);
        #1;
        rstn = 1;

        // white pixel
        push(8'd255); push(8'd255); push(8'd255);
        for (int i = 0; i < 8; i++) cycle(1, 1, 0);
        check("white_count", {16'd0, pixel_count}, 1);

        // primaries plus a mixed pixel at full throughput
        push(8'd255); push(8'd0);   push(8'd0);
        push(8'd0);   push(8'd255); push(8'd0);
        push(8'd0);   push(8'd0);   push(8'd255);
        push(8'd100); push(8'd150); push(8'd200);
        win_rd = 0;
        for (int i = 0; i < 12; i++) cycle(1, 1, 0);
        check("stream_reads", win_rd, 12);
        for (int i = 0; i < 6; i++) cycle(1, 1, 0);
        check("four_count", {16'd0, pixel_count}, 5);

        // back-pressure: only R,G of the second pixel may be consumed
        for (int i = 0; i < 6; i++) push(8'($urandom_range(1, 255)));
        win_rd = 0;
        for (int i = 0; i < 15; i++) cycle(0, 1, 0);
        check("bp_reads", win_rd, 5);
        check("bp_left", fq.size(), 1);
        for (int i = 0; i < 10; i++) cycle(1, 1, 0);

        // one byte every 4 cycles
        for (int i = 0; i < 12; i++) begin
            push(8'($urandom_range(0, 255)));
            for (int k = 0; k < 4; k++) cycle(1, 1, 0);
        end
        for (int i = 0; i < 4; i++) cycle(1, 1, 0);

        // en dropped after the G byte
        push(8'($urandom_range(0, 255)));
        push(8'($urandom_range(0, 255)));
        for (int i = 0; i < 4; i++) cycle(1, 1, 0);
        push(8'($urandom_range(0, 255)));
        win_rd = 0;
        for (int i = 0; i < 10; i++) cycle(1, 0, 0);
        check("en_low_reads", win_rd, 0);
        for (int i = 0; i < 6; i++) cycle(1, 1, 0);
        check("en_drain", exp_q.size(), 0);

        // randomized traffic: random bytes, ready, starvation and enable
        for (int i = 0; i < 60; i++) push(8'($urandom_range(0, 255)));
        for (int i = 0; i < 400; i++)
            cycle(($urandom % 4) != 0, ($urandom % 8) != 0, ($urandom % 5) == 0);
        for (int i = 0; i < 20; i++) cycle(1, 1, 0);
        check("rand_drain", exp_q.size(), 0);
        check("rand_fifo", fq.size(), 0);

        // reset after R,G consumed, with a fresh pixel afterwards
        push(8'd200); push(8'd100);
        for (int i = 0; i < 4; i++) cycle(1, 1, 0);
        #2;
        fifo_empty = 0;
        en = 1;
        rstn = 0;
        #1;
        check("mid_rst_valid", {31'd0, gray_valid}, 0);
        check("mid_rst_out", {24'd0, gray_out}, 0);
        check("mid_rst_count", {16'd0, pixel_count}, 0);
        check("mid_rst_rd", {31'd0, fifo_rd}, 0);
        fq.delete(); part.delete(); exp_q.delete();
        model_cnt = 0; rd_total = 0; last_b = -100;
        prev_hold = 0; prev_valid = 0;
        @(posedge clk);
        #1;
        rstn = 1;
        push(8'd10); push(8'd220); push(8'd90);
        for (int i = 0; i < 8; i++) cycle(1, 1, 0);
        check("post_rst_drain", exp_q.size(), 0);
        check("post_rst_count", {16'd0, pixel_count}, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
